snake_turn_queue: RTL and testbench

Multi-player, buffered successor to the single-register turn decoder. Each player channel edge-detects its four direction buttons and accepts only turns perpendicular to the most recently accepted heading. Accepted turns go into a small per-channel FIFO, and one entry is applied per movement tick. Sits between the debounced button inputs and the snake movement/collision logic, so fast double-taps (e.g. up-then-left within one move period) are no longer lost.

---
 rtl/snake_turn_queue_pkg.sv | 16 +
 rtl/snake_turn_queue_if.sv | 29 ++
 rtl/snake_turn_queue_fifo_ch.sv | 109 ++++++++++
 rtl/snake_turn_queue.sv | 40 ++++
 tb/tb_snake_turn_queue.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_turn_queue_pkg.sv
// Direction encoding shared by the turn queue and the movement/collision blocks.
package snake_dir_pkg;

  // Bit 0 is the axis: 0 = vertical, 1 = horizontal.
  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  function automatic logic same_axis(input dir_t a, input dir_t b);
    return a[0] == b[0];
  endfunction

endpackage

// File: rtl/snake_turn_queue_if.sv
// Button/tick/heading bundle for all player channels of the turn queue.
interface snake_turn_queue_if #(
  parameter int unsigned N_PLAYERS = 1,
  parameter int unsigned DEPTH     = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [4*N_PLAYERS-1:0]  btn;
  logic [N_PLAYERS-1:0]    step;
  logic [2*N_PLAYERS-1:0]  direction;
  logic [N_PLAYERS*CW-1:0] queue_count;
  logic [N_PLAYERS-1:0]    dropped;

  modport master (
    output btn,
    output step,
    input  direction,
    input  queue_count,
    input  dropped
  );

  modport slave (
    input  btn,
    input  step,
    output direction,
    output queue_count,
    output dropped
  );
endinterface

// File: rtl/snake_turn_queue_fifo_ch.sv
// One player channel: button edge detect, perpendicular-turn filter,
// small turn FIFO and the registered heading it feeds on each step.
module turn_fifo_ch
  import snake_dir_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter dir_t        INIT_DIR = RIGHT,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    btn,
  input  logic          step,
  output dir_t          direction,
  output logic [CW-1:0] queue_count,
  output logic          dropped
);

  // DEPTH=1 still needs a 1-bit pointer; it simply never leaves zero.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    btn_q;
  logic [3:0]    press;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] last_ptr;
  logic [CW-1:0] count;
  dir_t          mem [DEPTH];
  dir_t          tail;
  dir_t          cand_dir;
  logic          cand_valid;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pick at most one accepted turn and decide push/pop/drop for this cycle.
  always_comb begin
    press      = btn & ~btn_q;
    last_ptr   = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    tail       = (count != '0) ? mem[last_ptr] : direction;
    cand_valid = 1'b0;
    cand_dir   = tail;
    // btn bit order is {left, down, right, up}
    if (!same_axis(tail, LEFT)) begin
      if (press[3]) begin
        cand_valid = 1'b1;
        cand_dir   = LEFT;
      end else if (press[1]) begin
        cand_valid = 1'b1;
        cand_dir   = RIGHT;
      end
    end else begin
      if (press[0]) begin
        cand_valid = 1'b1;
        cand_dir   = UP;
      end else if (press[2]) begin
        cand_valid = 1'b1;
        cand_dir   = DOWN;
      end
    end
    full    = (count == CW'(DEPTH));
    do_pop  = step && (count != '0);
    // A full FIFO still accepts when the same-cycle pop frees the head slot.
    do_push = cand_valid && (!full || step);
    do_drop = cand_valid && full && !step;
  end

  // Control state: edge-detect history, heading, pointers, count, drop pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q     <= '1;
      direction <= INIT_DIR;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      dropped   <= 1'b0;
    end else begin
      btn_q   <= btn;
      dropped <= do_drop;
      if (do_pop) begin
        direction <= mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= cand_dir;
    end
  end

  assign queue_count = count;

endmodule

// File: rtl/snake_turn_queue.sv
// Multi-player buffered turn decoder: one independent turn_fifo_ch per player.
module snake_turn_queue
  import snake_dir_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 1,
  parameter int unsigned DEPTH     = 2,
  parameter dir_t        INIT_DIR  = RIGHT
) (
  input  logic              clock,
  input  logic              reset,
  snake_turn_queue_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  dir_t [N_PLAYERS-1:0]          dir_arr;
  logic [N_PLAYERS-1:0][CW-1:0]  cnt_arr;
  logic [N_PLAYERS-1:0]          drop_arr;

  // One channel per player; the top only slices the shared buses.
  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_ch
    turn_fifo_ch #(
      .DEPTH    (DEPTH),
      .INIT_DIR (INIT_DIR)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .btn         (bus.btn[4*p +: 4]),
      .step        (bus.step[p]),
      .direction   (dir_arr[p]),
      .queue_count (cnt_arr[p]),
      .dropped     (drop_arr[p])
    );
  end

  assign bus.direction   = dir_arr;
  assign bus.queue_count = cnt_arr;
  assign bus.dropped     = drop_arr;

endmodule

// File: tb/tb_snake_turn_queue.sv
// Bench for snake_turn_queue with two channels, DEPTH=2, INIT_DIR=RIGHT.
module tb_snake_turn_queue;
  import snake_dir_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned DP = 2;
  localparam int unsigned CW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  snake_turn_queue_if #(.N_PLAYERS(NP), .DEPTH(DP)) bus ();

  snake_turn_queue #(
    .N_PLAYERS (NP),
    .DEPTH     (DP),
    .INIT_DIR  (RIGHT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of pending turns plus heading per channel.
  dir_t       m_dir  [NP];
  dir_t       m_q    [NP][$];
  logic [3:0] m_bq   [NP];
  logic       m_drop [NP];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_clk(input logic r, input logic [7:0] b, input logic [1:0] s);
    for (int p = 0; p < NP; p++) begin
      logic [3:0] pb;
      logic [3:0] press;
      dir_t       tail;
      dir_t       pri [4];
      dir_t       cand;
      dir_t       d;
      bit         got;
      int         had;
      pb = b[4*p +: 4];
      if (r) begin
        m_q[p].delete();
        m_dir[p]  = RIGHT;
        m_bq[p]   = '1;
        m_drop[p] = 1'b0;
      end else begin
        press = pb & ~m_bq[p];
        tail  = (m_q[p].size() > 0) ? m_q[p][$] : m_dir[p];
        pri   = '{LEFT, RIGHT, UP, DOWN};
        got   = 0;
        cand  = tail;
        // button index equals the direction code; first perpendicular wins
        foreach (pri[i]) begin
          d = pri[i];
          if (!got && press[d] && (d[0] != tail[0])) begin
            got  = 1;
            cand = d;
          end
        end
        had       = m_q[p].size();
        m_drop[p] = 1'b0;
        if (s[p] && had > 0) m_dir[p] = m_q[p].pop_front();
        if (got) begin
          if (had < int'(DP) || s[p]) m_q[p].push_back(cand);
          else m_drop[p] = 1'b1;
        end
        m_bq[p] = pb;
      end
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] b, input logic [1:0] s);
    reset    = r;
    bus.btn  = b;
    bus.step = s;
    model_clk(r, b, s);
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("model_dir_ch%0d", p), int'(bus.direction[2*p +: 2]), int'(m_dir[p]));
      chk($sformatf("model_cnt_ch%0d", p), int'(bus.queue_count[CW*p +: CW]), m_q[p].size());
      chk($sformatf("model_drop_ch%0d", p), int'(bus.dropped[p]), int'(m_drop[p]));
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic       s;
    int         ed;
    int         ec;
    int         edr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] b, input logic s,
                              input int ed, input int ec, input int edr);
    vec_t v;
    v.rst = r; v.b = b; v.s = s; v.ed = ed; v.ec = ec; v.edr = edr;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lvl;
    logic [1:0] st;
    logic       rr;
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = RIGHT; m_bq[p] = '1; m_drop[p] = 1'b0;
    end
    reset    = 1'b1;
    bus.btn  = '0;
    bus.step = '0;

    // Channel 0 vectors: btn bits {left,down,right,up}; ch1 stays idle.
    //   rst   btn      step dir   cnt drop
    add(1'b1, 4'b0010, 1'b0, 1, 0, 0);  // reset with right held
    add(1'b1, 4'b0010, 1'b0, 1, 0, 0);
    add(1'b0, 4'b0010, 1'b0, 1, 0, 0);  // held through release: no press
    add(1'b0, 4'b0000, 1'b0, 1, 0, 0);
    add(1'b0, 4'b0001, 1'b0, 1, 1, 0);  // up queued
    add(1'b0, 4'b0000, 1'b0, 1, 1, 0);
    add(1'b0, 4'b0000, 1'b0, 1, 1, 0);
    add(1'b0, 4'b1000, 1'b0, 1, 2, 0);  // left queued behind up
    add(1'b0, 4'b0000, 1'b1, 0, 1, 0);  // step -> UP
    add(1'b0, 4'b0000, 1'b1, 3, 0, 0);  // step -> LEFT
    add(1'b0, 4'b0001, 1'b0, 3, 1, 0);
    add(1'b0, 4'b0000, 1'b1, 0, 0, 0);  // heading UP
    add(1'b0, 4'b0100, 1'b0, 0, 0, 0);  // reverse ignored
    add(1'b0, 4'b0000, 1'b0, 0, 0, 0);
    add(1'b0, 4'b1011, 1'b0, 0, 1, 0);  // up+left+right: only LEFT
    add(1'b0, 4'b0000, 1'b1, 3, 0, 0);
    add(1'b0, 4'b0001, 1'b0, 3, 1, 0);  // fill {UP, LEFT}
    add(1'b0, 4'b1000, 1'b0, 3, 2, 0);
    add(1'b0, 4'b0100, 1'b0, 3, 2, 1);  // full, no step: dropped
    add(1'b0, 4'b0000, 1'b0, 3, 2, 0);
    add(1'b0, 4'b0100, 1'b1, 0, 2, 0);  // full with step: pushed
    add(1'b0, 4'b0000, 1'b1, 3, 1, 0);
    add(1'b0, 4'b0000, 1'b1, 2, 0, 0);
    add(1'b0, 4'b0000, 1'b1, 2, 0, 0);  // empty step holds
    add(1'b0, 4'b0010, 1'b0, 2, 1, 0);
    add(1'b0, 4'b0000, 1'b1, 1, 0, 0);  // heading RIGHT
    add(1'b0, 4'b0001, 1'b1, 1, 1, 0);  // empty: step + press pushes only
    add(1'b0, 4'b0000, 1'b1, 0, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, {4'b0000, tbl[i].b}, {1'b0, tbl[i].s});
      chk($sformatf("vec%0d_dir0", i), int'(bus.direction[1:0]), tbl[i].ed);
      chk($sformatf("vec%0d_cnt0", i), int'(bus.queue_count[1:0]), tbl[i].ec);
      chk($sformatf("vec%0d_drop0", i), int'(bus.dropped[0]), tbl[i].edr);
      chk($sformatf("vec%0d_dir1", i), int'(bus.direction[3:2]), 1);
      chk($sformatf("vec%0d_cnt1", i), int'(bus.queue_count[3:2]), 0);
    end

    // Channel 1 active while channel 0 idles, then a reset flushes both.
    tick(1'b0, 8'h10, 2'b00);
    chk("ch1_cnt_a", int'(bus.queue_count[3:2]), 1);
    chk("ch0_dir_a", int'(bus.direction[1:0]), 0);
    tick(1'b0, 8'h80, 2'b00);
    chk("ch1_cnt_b", int'(bus.queue_count[3:2]), 2);
    tick(1'b0, 8'h00, 2'b10);
    chk("ch1_dir_c", int'(bus.direction[3:2]), 0);
    chk("ch1_cnt_c", int'(bus.queue_count[3:2]), 1);
    chk("ch0_cnt_c", int'(bus.queue_count[1:0]), 0);
    tick(1'b0, 8'h08, 2'b00);
    chk("ch0_cnt_d", int'(bus.queue_count[1:0]), 1);
    tick(1'b1, 8'h00, 2'b00);
    chk("rst_dir0", int'(bus.direction[1:0]), 1);
    chk("rst_dir1", int'(bus.direction[3:2]), 1);
    chk("rst_cnt", int'(bus.queue_count), 0);
    chk("rst_drop", int'(bus.dropped), 0);
    tick(1'b0, 8'h00, 2'b00);

    // Random traffic on both channels against the reference model.
    lvl = '0;
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 8; k++) if ($urandom_range(3) == 0) lvl[k] = ~lvl[k];
      for (int k = 0; k < 2; k++) st[k] = ($urandom_range(2) == 0);
      rr = ($urandom_range(79) == 0);
      tick(rr, lvl, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
